// File: rtl/fizzbuzz_line_formatter.sv
// fizzbuzz_line_formatter
//   Turns (value, fizz, buzz, fizzbuzz) tuples into ASCII text lines on a
//   valid/ready byte stream. Each line is "FizzBuzz", "Fizz", "Buzz" or the
//   unsigned decimal value, followed by an end-of-line. Tuples wait in a small
//   FIFO until the line engine picks them up.
//
//   Build option: define FIZZBUZZ_FMT_CRLF_EN to end lines with 0x0D 0x0A
//   instead of the single byte 0x0A. In both builds out_last marks the 0x0A.
//
// Ports
//   clk          clock, rising edge
//   resetn       synchronous active-low reset
//   in_valid     tuple present
//   in_ready     a tuple can be accepted (FIFO not full)
//   in_value     counter value, VAL_W bits (VAL_W <= 13, at most 4 digits)
//   in_fizz      value divisible by FIZZ
//   in_buzz      value divisible by BUZZ
//   in_fizzbuzz  value divisible by both
//   out_valid    out_data holds a byte
//   out_ready    sink accepts the byte
//   out_data     ASCII byte
//   out_last     final byte of a line
module fizzbuzz_line_formatter #(
  parameter int VAL_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_fizz,
  input  logic             in_buzz,
  input  logic             in_fizzbuzz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WORD,
    S_DIGITS,
`ifdef FIZZBUZZ_FMT_CRLF_EN
    S_CR,
`endif
    S_EOL
  } state_t;

`ifdef FIZZBUZZ_FMT_CRLF_EN
  localparam state_t S_EOL_FIRST = S_CR;
`else
  localparam state_t S_EOL_FIRST = S_EOL;
`endif

  // ---------------- tuple FIFO ----------------
  logic [VAL_W+2:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, empty;

  assign in_ready = resetn && (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_value, in_fizz, in_buzz, in_fizzbuzz};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- head-of-FIFO decode ----------------
  logic [VAL_W+2:0] head;
  logic [13:0]      head_v;
  logic             head_fizz, head_buzz, head_fb, head_word;
  logic [2:0]       head_wstart, head_wend;
  logic [3:0]       head_dig [4];
  logic [1:0]       head_top;

  assign head      = mem[rd_ptr];
  assign head_v    = 14'(head[VAL_W+2:3]);
  assign head_fizz = head[2];
  assign head_buzz = head[1];
  assign head_fb   = head[0];
  assign head_word = head_fb || head_fizz || head_buzz;

  // "Fizz" and "Buzz" are the two halves of the "FizzBuzz" ROM, so a word is
  // just a start/end pointer pair into it.
  always_comb begin
    head_wstart = 3'd0;
    head_wend   = 3'd7;
    if (!head_fb) begin
      if (head_fizz) begin
        head_wstart = 3'd0;
        head_wend   = 3'd3;
      end else begin
        head_wstart = 3'd4;
        head_wend   = 3'd7;
      end
    end
  end

  always_comb begin
    head_dig[0] = 4'(head_v % 14'd10);
    head_dig[1] = 4'((head_v / 14'd10) % 14'd10);
    head_dig[2] = 4'((head_v / 14'd100) % 14'd10);
    head_dig[3] = 4'(head_v / 14'd1000);
    if      (head_v >= 14'd1000) head_top = 2'd3;
    else if (head_v >= 14'd100)  head_top = 2'd2;
    else if (head_v >= 14'd10)   head_top = 2'd1;
    else                         head_top = 2'd0;
  end

  // ---------------- line engine ----------------
  state_t     state, state_next;
  logic [2:0] word_ptr, word_end;
  logic [3:0] dig [4];
  logic [1:0] dig_ptr;
  logic       step;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: if (!empty) pop = 1'b1;
      S_WORD: if (out_ready) begin
        if (word_ptr == word_end) state_next = S_EOL_FIRST;
        else                      step       = 1'b1;
      end
      S_DIGITS: if (out_ready) begin
        if (dig_ptr == 2'd0) state_next = S_EOL_FIRST;
        else                 step       = 1'b1;
      end
`ifdef FIZZBUZZ_FMT_CRLF_EN
      S_CR: if (out_ready) state_next = S_EOL;
`endif
      S_EOL: if (out_ready) begin
        if (!empty) pop        = 1'b1;
        else        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Loading from IDLE and from an accepted EOL share one path, which is
    // what makes back-to-back lines bubble-free.
    if (pop) state_next = head_word ? S_WORD : S_DIGITS;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      word_ptr <= head_wstart;
      word_end <= head_wend;
      dig      <= head_dig;
      dig_ptr  <= head_top;
    end else if (step) begin
      if (state == S_WORD) word_ptr <= word_ptr + 3'd1;
      else                 dig_ptr  <= dig_ptr - 2'd1;
    end
  end

  function automatic logic [7:0] word_char(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h46;  // F
      3'd1:    return 8'h69;  // i
      3'd4:    return 8'h42;  // B
      3'd5:    return 8'h75;  // u
      default: return 8'h7A;  // z
    endcase
  endfunction

  // Outputs depend only on registers, so they hold while stalled.
  always_comb begin
    out_valid = (state != S_IDLE);
    out_last  = (state == S_EOL);
    out_data  = 8'h00;
    case (state)
      S_WORD:   out_data = word_char(word_ptr);
      S_DIGITS: out_data = {4'h3, dig[dig_ptr]};
`ifdef FIZZBUZZ_FMT_CRLF_EN
      S_CR:     out_data = 8'h0D;
`endif
      S_EOL:    out_data = 8'h0A;
      default:  out_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_fizzbuzz_line_formatter.sv
module tb_fizzbuzz_line_formatter;

  localparam int VAL_W = 7;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic [VAL_W-1:0] in_value = '0;
  logic             in_fizz = 1'b0, in_buzz = 1'b0, in_fizzbuzz = 1'b0;
  logic             in_ready, out_valid, out_last, out_ready;
  logic [7:0]       out_data;
  logic             ready_set = 1'b1, rand_mode = 1'b0, rnd_bit = 1'b1;

  assign out_ready = rand_mode ? rnd_bit : ready_set;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 1) == 1);
  end

  fizzbuzz_line_formatter #(.VAL_W(VAL_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_fizz(in_fizz), .in_buzz(in_buzz), .in_fizzbuzz(in_fizzbuzz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  logic [7:0]  rx_d [$];
  logic        rx_l [$];
  int unsigned rx_t [$];
  int unsigned cyc = 0;
  logic        prev_stall = 1'b0, prev_l = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_d));
      chk("stall_last", 32'(out_last), 32'(prev_l));
    end
    prev_stall = resetn && out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
    if (resetn && out_valid && out_ready) begin
      rx_d.push_back(out_data);
      rx_l.push_back(out_last);
      rx_t.push_back(cyc);
    end
  end

  // ---------------- helpers ----------------
  logic        gap_check = 1'b0, gap_armed = 1'b0;
  int unsigned last_t = 0;

  task automatic get_byte(output logic [7:0] d, output logic l, output logic ok);
    int n = 0;
    while (rx_d.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = 1'b0; d = 8'h00; l = 1'b0;
    if (rx_d.size() == 0) begin
      total++; bad++;
      $display("FAIL byte_timeout: got no byte expected one within 300 cycles");
    end else begin
      int unsigned t;
      d = rx_d.pop_front();
      l = rx_l.pop_front();
      t = rx_t.pop_front();
      ok = 1'b1;
      if (gap_check && gap_armed) chk("no_bubble", t, last_t + 1);
      gap_armed = 1'b1;
      last_t = t;
    end
  endtask

  task automatic expect_line(input string body, input string tag);
    logic [7:0] d;
    logic l, ok;
    for (int k = 0; k < body.len(); k++) begin
      get_byte(d, l, ok);
      if (!ok) return;
      chk({tag, "_char"}, 32'(d), {24'h0, body[k]});
      chk({tag, "_last0"}, 32'(l), 32'd0);
    end
`ifdef FIZZBUZZ_FMT_CRLF_EN
    get_byte(d, l, ok);
    if (!ok) return;
    chk({tag, "_cr"}, 32'(d), 32'h0D);
    chk({tag, "_cr_last"}, 32'(l), 32'd0);
`endif
    get_byte(d, l, ok);
    if (!ok) return;
    chk({tag, "_lf"}, 32'(d), 32'h0A);
    chk({tag, "_lf_last"}, 32'(l), 32'd1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [VAL_W-1:0] v, input logic fz, input logic bz, input logic fb);
    int n = 0;
    in_valid = 1'b1; in_value = v; in_fizz = fz; in_buzz = bz; in_fizzbuzz = fb;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic string v2s(input logic [63:0] b);
    string s = "";
    for (int k = 7; k >= 0; k--)
      if (b[k*8 +: 8] != 8'h00) s = $sformatf("%s%c", s, b[k*8 +: 8]);
    return s;
  endfunction

  function automatic string ref_line(input int v);
    if (v % 15 == 0) return "FizzBuzz";
    if (v % 3 == 0)  return "Fizz";
    if (v % 5 == 0)  return "Buzz";
    return $sformatf("%0d", v);
  endfunction

  typedef struct packed {
    logic [VAL_W-1:0] v;
    logic             fz, bz, fb;
    logic [63:0]      body;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{7'd0,   1'b0, 1'b0, 1'b1, "FizzBuzz"};
    tbl[1]  = '{7'd10,  1'b0, 1'b1, 1'b0, "Buzz"};
    tbl[2]  = '{7'd99,  1'b1, 1'b0, 1'b0, "Fizz"};
    tbl[3]  = '{7'd98,  1'b0, 1'b0, 1'b0, "98"};
    tbl[4]  = '{7'd100, 1'b0, 1'b0, 1'b0, "100"};
    tbl[5]  = '{7'd0,   1'b0, 1'b0, 1'b0, "0"};
    tbl[6]  = '{7'd127, 1'b0, 1'b0, 1'b0, "127"};
    tbl[7]  = '{7'd15,  1'b1, 1'b1, 1'b1, "FizzBuzz"};
    tbl[8]  = '{7'd30,  1'b1, 1'b1, 1'b0, "Fizz"};
    tbl[9]  = '{7'd3,   1'b1, 1'b0, 1'b0, "Fizz"};
    tbl[10] = '{7'd9,   1'b0, 1'b0, 1'b0, "9"};
    tbl[11] = '{7'd5,   1'b0, 1'b1, 1'b0, "Buzz"};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // first-byte latency
    push(7'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_valid_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_edge2", 32'(out_valid), 32'd1);
    chk("lat_data_edge2", 32'(out_data), 32'h37);
    expect_line("7", "lat");
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      push(tbl[i].v, tbl[i].fz, tbl[i].bz, tbl[i].fb);
      expect_line(v2s(tbl[i].body), $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // backpressure: 4 in FIFO plus 1 in the line engine
    ready_set = 1'b0;
    for (int v = 1; v <= 5; v++) push(VAL_W'(v), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h31);
    end
    @(posedge clk); #1;
    ready_set = 1'b1;
    gap_check = 1'b1; gap_armed = 1'b0;
    for (int v = 1; v <= 5; v++) expect_line($sformatf("%0d", v), "bp");
    gap_check = 1'b0;
    @(posedge clk); #1;

    // random backpressure over a reference FizzBuzz run
    rand_mode = 1'b1;
    fork
      for (int v = 0; v < 100; v++)
        push(VAL_W'(v), (v % 3 == 0), (v % 5 == 0), (v % 15 == 0));
      for (int v = 0; v < 100; v++)
        expect_line(ref_line(v), "rnd");
    join
    @(posedge clk); #1;
    rand_mode = 1'b0;

    // reset in the middle of "FizzBuzz" with more entries queued
    ready_set = 1'b0;
    push(7'd0, 1'b0, 1'b0, 1'b1);
    push(7'd11, 1'b0, 1'b0, 1'b0);
    push(7'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_first", 32'(out_data), 32'h46);
    @(posedge clk); #1;
    ready_set = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready_set = 1'b0;
    @(negedge clk);
    chk("mid_third", 32'(out_data), 32'h7A);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'h00);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_in_ready1", 32'(in_ready), 32'd1);
    chk("mid_rx_count", rx_d.size(), 32'd2);
    if (rx_d.size() == 2) begin
      chk("mid_rx0", 32'(rx_d[0]), 32'h46);
      chk("mid_rx1", 32'(rx_d[1]), 32'h69);
    end
    rx_d.delete(); rx_l.delete(); rx_t.delete();
    @(posedge clk); #1;
    ready_set = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    chk("mid_rx_empty", rx_d.size(), 32'd0);
    @(posedge clk); #1;
    push(7'd4, 1'b0, 1'b0, 1'b0);
    expect_line("4", "after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
